// File: rtl/debug_ctrl.sv
// debug_ctrl: debounced board controls driving the CPU debug port (run/step, step pulses, register address, display capture)
module debug_ctrl #(
    parameter int DEBOUNCE_CYCLES  = 1000000,
    parameter int STEP_HIGH_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        run_sw,
    input  logic        btn_step,
    input  logic        btn_up,
    input  logic        btn_down,
    input  logic [31:0] debug_data,
    output logic        debug_en,
    output logic        debug_step,
    output logic [6:0]  debug_addr,
    output logic [31:0] disp_data,
    output logic        disp_chg
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int SW = $clog2(STEP_HIGH_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

    logic [3:0]    w_raw;
    logic [3:0]    r_s1;
    logic [3:0]    r_s2;
    logic [3:0]    r_stb;
    logic [CW-1:0] r_cnt [4];
    logic [3:1]    r_stb_d;
    logic [3:1]    w_press;
    state_t        r_state;
    state_t        w_state_nxt;
    logic [SW-1:0] r_scnt;
    logic [SW-1:0] w_scnt_nxt;
    logic          r_en;
    logic          r_step;
    logic [6:0]    r_addr;
    logic [31:0]   r_disp;
    logic          r_chg;

    // bit 0 is the run switch, bits 1..3 are step/up/down buttons
    assign w_raw   = {btn_down, btn_up, btn_step, run_sw};
    assign w_press = r_stb[3:1] & ~r_stb_d;

    // two-flop synchronisers for the asynchronous board inputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1 <= '0;
            r_s2 <= '0;
        end else begin
            r_s1 <= w_raw;
            r_s2 <= r_s1;
        end
    end

    // accept a new level only after it has been seen for DEBOUNCE_CYCLES consecutive cycles
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stb <= '0;
            r_cnt <= '{default: '0};
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (r_s2[i] == r_stb[i]) begin
                    r_cnt[i] <= '0;
                end else if (r_cnt[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
                    r_stb[i] <= r_s2[i];
                    r_cnt[i] <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + CW'(1);
                end
            end
        end
    end

    // edge memory for press detection, run mode, address and display capture
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stb_d <= '0;
            r_en    <= 1'b1;
            r_addr  <= '0;
            r_disp  <= '0;
            r_chg   <= 1'b0;
        end else begin
            r_stb_d <= r_stb[3:1];
            r_en    <= ~r_stb[0];
            r_addr  <= (w_press[2] & ~w_press[3]) ? r_addr + 7'd1 :
                       (w_press[3] & ~w_press[2]) ? r_addr - 7'd1 : r_addr;
            r_disp  <= debug_data;
            r_chg   <= debug_data != r_disp;
        end
    end

    // step FSM state register; debug_step is registered from the next state
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_scnt  <= '0;
            r_step  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_scnt  <= w_scnt_nxt;
            r_step  <= w_state_nxt == HIGH;
        end
    end

    // step FSM next state: high phase, low guard phase, abort when run mode is entered
    always_comb begin
        w_state_nxt = r_state;
        w_scnt_nxt  = r_scnt;
        if (r_state == IDLE) begin
            if (w_press[1] && r_en) begin
                w_state_nxt = HIGH;
                w_scnt_nxt  = '0;
            end
        end else if (!r_en) begin
            w_state_nxt = IDLE;
            w_scnt_nxt  = '0;
        end else if (r_scnt == SW'(STEP_HIGH_CYCLES - 1)) begin
            w_state_nxt = (r_state == HIGH) ? LOW : IDLE;
            w_scnt_nxt  = '0;
        end else begin
            w_scnt_nxt = r_scnt + SW'(1);
        end
    end

    assign debug_en   = r_en;
    assign debug_step = r_step;
    assign debug_addr = r_addr;
    assign disp_data  = r_disp;
    assign disp_chg   = r_chg;
endmodule
